r4_sdf_stage_ctrl: RTL and testbench

//  Sequencer for one radix-4 single-delay-feedback (SDF) IFFT stage in the 5G NR IFFT/CP chain.

---
 rtl/r4_sdf_stage_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_r4_sdf_stage_ctrl.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/r4_sdf_stage_ctrl.sv
// r4_sdf_stage_ctrl: sequencer for one radix-4 SDF IFFT stage.
// Tracks the sample position inside each N-point frame. It drives the delay-line
// phase/address, the butterfly enable, the emitted-output index, the twiddle address
// and the output framing. It also handles the post-frame drain and the back-to-back
// frame overlap.
// Optional feature: define R4_CTRL_STATS_EN to get frame/drop counters; otherwise
// frame_cnt_o and drop_cnt_o are tied to 0.
module r4_sdf_stage_ctrl #(
    parameter int N  = 2048,
    parameter int L  = 256,
    parameter int AW = $clog2(N),
    parameter int LW = $clog2(L)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          in_valid_i,
    input  logic          in_sof_i,
    output logic          in_ready_o,
    output logic [1:0]    phase_o,
    output logic [LW-1:0] dl_addr_o,
    output logic          bf_en_o,
    output logic          out_valid_o,
    output logic [1:0]    out_idx_o,
    output logic [AW-1:0] tw_addr_o,
    output logic          out_sof_o,
    output logic          out_eof_o,
    output logic          busy_o,
    output logic          err_sof_o,
    output logic [15:0]   frame_cnt_o,
    output logic [15:0]   drop_cnt_o
);
    localparam int DW = LW + 2;
    localparam logic [DW-1:0] DRN_LAST = DW'(3*L - 1);
    localparam logic [AW-1:0] POS_LAST = AW'(N - 1);
    localparam logic [AW-1:0] POS_SOF  = AW'(3*L);
    localparam logic [LW-1:0] DL_LAST  = LW'(L - 1);
    localparam logic [31:0]   N_U      = 32'(N);
    localparam logic [31:0]   K_U      = 32'(N / (4*L));

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

    state_e        state_q;
    logic [AW-1:0] pos_q;
    logic [DW-1:0] drn_q;
    logic          grp_ok_q;   // a completed group still owes outputs 0..2
    logic          fin_q;      // that group is the last one of its frame

    logic [1:0]    phase_q, out_idx_q;
    logic [LW-1:0] dl_addr_q;
    logic [AW-1:0] tw_addr_q;
    logic          bf_en_q, out_valid_q, out_sof_q, out_eof_q, err_sof_q;

    logic          accept, sof_go, err, samp_adv, drn_adv, drn_done, grp_set;
    logic          bf_d, lo_d, sof_d, eof_d;
    logic [AW-1:0] s_pos;
    logic [1:0]    ph_d, idx_d;
    logic [LW-1:0] dl_d;
    logic [31:0]   tw_full;
    logic [AW-1:0] tw_d;

    // Only a drain that has started self-advancing refuses input.
    assign in_ready_o = !(state_q == DRAIN && drn_q != '0);
    assign busy_o     = (state_q != IDLE);

    // Decode what happens this cycle and compute the next registered control word.
    always_comb begin
        accept   = in_valid_i & in_ready_o;
        sof_go   = accept & in_sof_i & (state_q == IDLE || state_q == DRAIN);
        err      = accept & in_sof_i & (state_q == RUN);
        samp_adv = sof_go | (accept & (state_q == RUN));
        drn_adv  = (state_q == DRAIN) & ~sof_go;
        drn_done = drn_adv & (drn_q == DRN_LAST);
        s_pos    = in_sof_i ? '0 : pos_q;
        ph_d     = '0;
        dl_d     = '0;
        if (samp_adv) begin
            ph_d = s_pos[LW +: 2];
            dl_d = s_pos[LW-1:0];
        end else if (drn_adv) begin
            ph_d = drn_q[LW +: 2];
            dl_d = drn_q[LW-1:0];
        end
        bf_d    = samp_adv & (ph_d == 2'd3);
        // A resync discards the pending group, so the sof sample emits nothing.
        lo_d    = (samp_adv | drn_adv) & (ph_d != 2'd3) & grp_ok_q & ~err;
        idx_d   = bf_d ? 2'd3 : (lo_d ? ph_d : 2'd0);
        tw_full = 32'(idx_d) * 32'(dl_d) * K_U;
        tw_d    = AW'(tw_full % N_U);
        sof_d   = samp_adv & (s_pos == POS_SOF);
        eof_d   = lo_d & (ph_d == 2'd2) & (dl_d == DL_LAST) & fin_q;
        grp_set = bf_d & (dl_d == DL_LAST);
    end

    // Sequencer FSM with registered per-sample outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            pos_q       <= '0;
            drn_q       <= '0;
            grp_ok_q    <= 1'b0;
            fin_q       <= 1'b0;
            phase_q     <= '0;
            dl_addr_q   <= '0;
            bf_en_q     <= 1'b0;
            out_valid_q <= 1'b0;
            out_idx_q   <= '0;
            tw_addr_q   <= '0;
            out_sof_q   <= 1'b0;
            out_eof_q   <= 1'b0;
            err_sof_q   <= 1'b0;
        end else begin
            phase_q     <= ph_d;
            dl_addr_q   <= dl_d;
            bf_en_q     <= bf_d;
            out_valid_q <= bf_d | lo_d;
            out_idx_q   <= idx_d;
            tw_addr_q   <= tw_d;
            out_sof_q   <= sof_d;
            out_eof_q   <= eof_d;
            err_sof_q   <= err;
            if (err || drn_done) begin
                grp_ok_q <= 1'b0;
                fin_q    <= 1'b0;
            end else if (grp_set) begin
                grp_ok_q <= 1'b1;
                fin_q    <= (s_pos == POS_LAST);
            end
            case (state_q)
                IDLE: if (sof_go) begin
                    state_q <= RUN;
                    pos_q   <= AW'(1);
                end
                RUN: if (accept) begin
                    if (in_sof_i) begin
                        pos_q <= AW'(1);
                    end else if (pos_q == POS_LAST) begin
                        state_q <= DRAIN;
                        pos_q   <= '0;
                        drn_q   <= '0;
                    end else begin
                        pos_q <= pos_q + 1'b1;
                    end
                end
                DRAIN: if (sof_go) begin
                    state_q <= RUN;
                    pos_q   <= AW'(1);
                end else if (drn_q == DRN_LAST) begin
                    state_q <= IDLE;
                    drn_q   <= '0;
                end else begin
                    drn_q <= drn_q + 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign phase_o     = phase_q;
    assign dl_addr_o   = dl_addr_q;
    assign bf_en_o     = bf_en_q;
    assign out_valid_o = out_valid_q;
    assign out_idx_o   = out_idx_q;
    assign tw_addr_o   = tw_addr_q;
    assign out_sof_o   = out_sof_q;
    assign out_eof_o   = out_eof_q;
    assign err_sof_o   = err_sof_q;

`ifdef R4_CTRL_STATS_EN
    logic [15:0] frame_cnt_q, drop_cnt_q;
    logic        drop_inc;

    // Ignored samples: refused by in_ready, or accepted without sof while waiting for a frame.
    assign drop_inc = (in_valid_i & ~accept) |
                      (accept & ~in_sof_i & (state_q == IDLE || state_q == DRAIN));

    // Frame counter wraps; drop counter saturates.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            frame_cnt_q <= '0;
            drop_cnt_q  <= '0;
        end else begin
            if (eof_d) frame_cnt_q <= frame_cnt_q + 1'b1;
            if (drop_inc && drop_cnt_q != 16'hFFFF) drop_cnt_q <= drop_cnt_q + 1'b1;
        end
    end

    assign frame_cnt_o = frame_cnt_q;
    assign drop_cnt_o  = drop_cnt_q;
`else
    assign frame_cnt_o = '0;
    assign drop_cnt_o  = '0;
`endif
endmodule

// File: tb/tb_r4_sdf_stage_ctrl.sv
// Scoreboard bench for r4_sdf_stage_ctrl (N=2048, L=256): the stimulus pushes the expected
// output stream, and a negedge monitor pops and compares every out_valid beat.
module tb_r4_sdf_stage_ctrl;
    localparam int N = 2048;
    localparam int L = 256;
    localparam int G = N / (4*L);
`ifdef R4_CTRL_STATS_EN
    localparam int STATS = 1;
`else
    localparam int STATS = 0;
`endif

    typedef struct {
        logic [1:0]  idx;
        logic [7:0]  dl;
        logic [10:0] tw;
        logic        sof;
        logic        eof;
    } exp_t;

    logic        clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, in_sof = 1'b0;
    logic        in_ready, bf_en, out_valid, out_sof, out_eof, busy, err_sof;
    logic [1:0]  phase, out_idx;
    logic [7:0]  dl_addr;
    logic [10:0] tw_addr;
    logic [15:0] frame_cnt, drop_cnt;

    r4_sdf_stage_ctrl #(.N(N), .L(L), .AW(11), .LW(8)) dut (
        .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_sof_i(in_sof),
        .in_ready_o(in_ready), .phase_o(phase), .dl_addr_o(dl_addr), .bf_en_o(bf_en),
        .out_valid_o(out_valid), .out_idx_o(out_idx), .tw_addr_o(tw_addr),
        .out_sof_o(out_sof), .out_eof_o(out_eof), .busy_o(busy), .err_sof_o(err_sof),
        .frame_cnt_o(frame_cnt), .drop_cnt_o(drop_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   nvec = 0, nbad = 0;
    int   n_out = 0, n_eof = 0, n_err = 0, rdy_low = 0, sof_cyc = -1, eof_cyc = -1;
    exp_t q[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nbad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    function automatic logic [63:0] pk(logic bf, logic [1:0] idx, logic [1:0] ph,
                                       logic [7:0] dl, logic [10:0] tw, logic s, logic e);
        return {38'b0, bf, idx, ph, dl, tw, s, e};
    endfunction

    function automatic void push(int idx, int dl, bit s, bit e);
        exp_t x;
        x.idx = 2'(idx);
        x.dl  = 8'(dl);
        x.tw  = 11'((idx * dl * G) % N);
        x.sof = s;
        x.eof = e;
        q.push_back(x);
    endfunction

    function automatic void push_bf(bit first);
        for (int d = 0; d < L; d++) push(3, d, first && d == 0, 1'b0);
    endfunction

    function automatic void push_lo(bit fin);
        for (int p = 0; p < 3; p++)
            for (int d = 0; d < L; d++) push(p, d, 1'b0, fin && p == 2 && d == L-1);
    endfunction

    // Expected beats for nf contiguous frames, including the trailing drain.
    function automatic void push_run(int nf);
        for (int f = 0; f < nf; f++)
            for (int g = 0; g < G; g++) begin
                if (g > 0 || f > 0) push_lo(g == 0 && f > 0);
                push_bf(g == 0);
            end
        push_lo(1'b1);
    endfunction

    // Monitor: compare each emitted beat against the scoreboard head.
    always @(negedge clk) begin
        if (rst_n) begin
            if (!in_ready) rdy_low++;
            if (err_sof) n_err++;
            if (out_valid) begin
                n_out++;
                if (out_sof) sof_cyc = cyc;
                if (out_eof) begin n_eof++; eof_cyc = cyc; end
                if (q.size() == 0) begin
                    nvec++; nbad++;
                    $display("FAIL unexpected_out: idx %0d dl %0d with empty scoreboard", out_idx, dl_addr);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("out_rec", pk(bf_en, out_idx, phase, dl_addr, tw_addr, out_sof, out_eof),
                        pk(e.idx == 2'd3, e.idx, e.idx, e.dl, e.tw, e.sof, e.eof));
                end
                if (out_idx == 2'd2 && dl_addr == 8'd100) chk("tw_i2_d100", 64'(tw_addr), 64'd400);
                if (out_idx == 2'd3 && dl_addr == 8'd255) chk("tw_i3_d255", 64'(tw_addr), 64'd1530);
                if (out_idx == 2'd0 && dl_addr == 8'd77)  chk("tw_i0", 64'(tw_addr), 64'd0);
            end else begin
                chk("idle_flags", {61'b0, bf_en, out_sof, out_eof}, 64'd0);
            end
        end
    end

    task automatic drv(input bit v, input bit s);
        @(posedge clk); #1;
        in_valid = v;
        in_sof   = s;
    endtask

    task automatic chk_reset(input string nm);
        chk({nm, "_outs"}, {3'b0, phase, dl_addr, bf_en, out_valid, out_idx, tw_addr, out_sof,
                            out_eof, busy, err_sof, frame_cnt, drop_cnt}, 64'd0);
        chk({nm, "_ready"}, 64'(in_ready), 64'd1);
    endtask

    // One frame of N samples; optional 10-cycle gap before sample gap_at.
    task automatic run_frame(input int gap_at, output int c768, output int clast);
        c768 = -1; clast = -1;
        for (int i = 0; i < N; i++) begin
            if (i == gap_at)
                for (int k = 0; k < 10; k++) begin
                    drv(1'b0, 1'b0);
                    if (k > 0) begin
                        @(negedge clk);
                        chk("gap_ctrl", {52'b0, out_valid, bf_en, phase, dl_addr}, 64'd0);
                    end
                end
            drv(1'b1, i == 0);
            if (i == 3*L) c768 = cyc;
            if (i == N-1) clast = cyc;
        end
    endtask

    task automatic wait_eof(input int tgt);
        int t = 0;
        while (n_eof < tgt && t < 3000) begin @(posedge clk); t++; end
        if (n_eof < tgt) begin
            nvec++; nbad++;
            $display("FAIL eof_timeout: got %0d eofs, want %0d", n_eof, tgt);
        end
    endtask

    int c768, cl, dummy, o0, e0, fc0, rl0, er0, sofa;

    initial begin
        // Power-on reset state.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_reset("por");
        rst_n = 1'b1;

        // Samples without sof while idle are ignored.
        repeat (3) drv(1'b1, 1'b0);
        drv(1'b0, 1'b0);
        @(negedge clk);
        chk("idle_ign_busy", 64'(busy), 64'd0);
        chk("idle_ign_out", 64'(n_out), 64'd0);
        chk("idle_ign_drop", 64'(drop_cnt), 64'(STATS * 3));

        // Single contiguous frame.
        o0 = n_out; fc0 = frame_cnt; er0 = n_err;
        push_run(1);
        run_frame(-1, c768, cl);
        drv(1'b0, 1'b0);
        wait_eof(1);
        chk("t2_sof_lat", 64'(sof_cyc), 64'(c768 + 1));
        chk("t2_nout", 64'(n_out - o0), 64'd2048);
        chk("t2_eof_cyc", 64'(eof_cyc), 64'(cl + 769));
        @(negedge clk);
        chk("t2_busy", 64'(busy), 64'd0);
        chk("t2_err", 64'(n_err - er0), 64'd0);
        chk("t2_fcnt", 64'(int'(frame_cnt) - fc0), 64'(STATS));

        // Back-to-back frames, second sof on drain cycle 0.
        o0 = n_out; fc0 = frame_cnt; rl0 = rdy_low;
        push_run(2);
        run_frame(-1, c768, dummy);
        sofa = sof_cyc;
        run_frame(-1, dummy, cl);
        chk("t3_ready", 64'(rdy_low - rl0), 64'd0);
        drv(1'b0, 1'b0);
        wait_eof(3);
        chk("t3_sofa_lat", 64'(sofa), 64'(c768 + 1));
        chk("t3_contig", 64'(eof_cyc - sofa + 1), 64'd4096);
        chk("t3_nout", 64'(n_out - o0), 64'd4096);
        chk("t3_fcnt", 64'(int'(frame_cnt) - fc0), 64'(STATS * 2));

        // 10-cycle input gap before sample 900.
        o0 = n_out;
        push_run(1);
        run_frame(900, c768, cl);
        drv(1'b0, 1'b0);
        wait_eof(4);
        chk("t5_nout", 64'(n_out - o0), 64'd2048);
        chk("t5_eof_cyc", 64'(eof_cyc), 64'(cl + 769));

        // Extra sof at sample 500 aborts the frame and restarts.
        o0 = n_out; e0 = n_eof; er0 = n_err;
        push_run(1);
        for (int i = 0; i < 500; i++) drv(1'b1, i == 0);
        run_frame(-1, c768, cl);
        drv(1'b0, 1'b0);
        wait_eof(e0 + 1);
        @(negedge clk);
        chk("t6_err", 64'(n_err - er0), 64'd1);
        chk("t6_sof_lat", 64'(sof_cyc), 64'(c768 + 1));
        chk("t6_nout", 64'(n_out - o0), 64'd2048);
        chk("t6_neof", 64'(n_eof - e0), 64'd1);

        // Reset in the middle of a drain, then a fresh frame.
        push_run(1);
        run_frame(-1, c768, cl);
        drv(1'b0, 1'b0);
        repeat (100) @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        chk_reset("t1_rst");
        chk("t1_busy", 64'(busy), 64'd0);
        q.delete();
        @(posedge clk); #1 rst_n = 1'b1;
        o0 = n_out; e0 = n_eof;
        push_run(1);
        run_frame(-1, c768, cl);
        drv(1'b0, 1'b0);
        wait_eof(e0 + 1);
        @(negedge clk);
        chk("t1_sof_lat", 64'(sof_cyc), 64'(c768 + 1));
        chk("t1_nout", 64'(n_out - o0), 64'd2048);
        chk("t1_fcnt", 64'(frame_cnt), 64'(STATS));
        chk("q_drained", 64'(q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end
endmodule
